// File: rtl/pbl_axi_pkg.sv
// Shared AXI definitions for the FIR sample-path burst master: FSM state
// encoding, fixed AXI field values and the 4 KB boundary check.
package pbl_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned AXI_4KB = 4096;

    // True when a burst of (len+1) 8-byte beats starting at page offset
    // addr_lo would run past the end of its 4 KB page. 13 bits hold the
    // worst case 4095 + 256*8 without overflow.
    function automatic logic crosses_4kb(input logic [11:0] addr_lo,
                                         input logic [7:0]  len);
        logic [12:0] span;
        span = ({5'd0, len} + 13'd1) << 3;
        return ({1'b0, addr_lo} + span) > 13'(AXI_4KB);
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst initiator: one command at a time, write data taken from a
// valid/ready stream, read data returned on a valid/ready stream. The data
// channels are pure pass-through; only control and address fields are held.
module axi_burst_master
    import pbl_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                a_clk,
    input  logic                a_rst_n,
    // command interface
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    // write data stream
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    // read data stream
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                rd_last,
    // status
    output logic                busy,
    output logic                done,
    output logic                err,
    // AXI write address
    output logic [ADDR_W-1:0]   a_awaddr,
    output logic                a_awvalid,
    input  logic                a_awready,
    output logic [7:0]          a_awlen,
    output logic [2:0]          a_awsize,
    output logic [1:0]          a_awburst,
    // AXI write data
    output logic                a_wvalid,
    input  logic                a_wready,
    output logic                a_wlast,
    output logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W/8-1:0] a_wstrb,
    // AXI write response
    input  logic                a_bvalid,
    output logic                a_bready,
    input  logic [1:0]          a_bresp,
    // AXI read address
    output logic                a_arvalid,
    input  logic                a_arready,
    output logic [ADDR_W-1:0]   a_araddr,
    output logic [2:0]          a_arsize,
    output logic [1:0]          a_arburst,
    output logic [7:0]          a_arlen,
    // AXI read data
    input  logic                a_rvalid,
    output logic                a_rready,
    input  logic                a_rlast,
    input  logic [DATA_W-1:0]   a_rdata,
    input  logic [1:0]          a_rresp
);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [8:0]          cnt_q;
    logic                err_acc_q;
    logic                awvalid_q;
    logic                arvalid_q;

    logic cmd_rejected;
    logic in_w;
    logic in_r;
    logic w_hs;
    logic r_hs;
    logic at_last;

    assign cmd_rejected = (cmd_addr[2:0] != 3'b000) || crosses_4kb(cmd_addr[11:0], cmd_len);
    assign in_w         = (state_q == ST_W);
    assign in_r         = (state_q == ST_R);
    assign w_hs         = in_w && wr_valid && a_wready;
    assign r_hs         = in_r && a_rvalid && rd_ready;
    assign at_last      = (cnt_q == {1'b0, len_q});

    // Burst sequencer: latches the command, walks the AXI phases, counts beats
    // and accumulates any error seen along the way.
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        cnt_q     <= '0;
                        err_acc_q <= 1'b0;
                        if (cmd_rejected) begin
                            err_acc_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end else if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            state_q   <= ST_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_AW: begin
                    if (a_awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (at_last) state_q <= ST_B;
                    end
                end
                ST_B: begin
                    if (a_bvalid) begin
                        if (a_bresp != AXI_RESP_OKAY) err_acc_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_AR: begin
                    if (a_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (a_rresp != AXI_RESP_OKAY) err_acc_q <= 1'b1;
                        // the slave's rlast ends the burst even if it comes early
                        if (a_rlast) begin
                            if (!at_last) err_acc_q <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = done && err_acc_q;

    assign a_awaddr  = addr_q;
    assign a_awlen   = len_q;
    assign a_awvalid = awvalid_q;
    assign a_awsize  = AXI_SIZE_8B;
    assign a_awburst = AXI_BURST_INCR;

    assign a_araddr  = addr_q;
    assign a_arlen   = len_q;
    assign a_arvalid = arvalid_q;
    assign a_arsize  = AXI_SIZE_8B;
    assign a_arburst = AXI_BURST_INCR;

    assign a_wvalid  = in_w && wr_valid;
    assign wr_ready  = in_w && a_wready;
    assign a_wdata   = wr_data;
    assign a_wlast   = in_w && at_last;
    assign a_wstrb   = '1;

    assign a_bready  = (state_q == ST_B);

    assign rd_valid  = in_r && a_rvalid;
    assign a_rready  = in_r && rd_ready;
    assign rd_data   = a_rdata;
    assign rd_last   = in_r && a_rlast;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: a randomised AXI slave and stream source/sink
// drive the DUT while a transaction-level model (handshake counts per
// command) predicts every output on every cycle.
module tb_axi_burst_master;

    logic        a_clk = 1'b0;
    logic        a_rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [63:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [63:0] rd_data;
    logic        rd_valid, rd_ready, rd_last;
    logic        busy, done, err;
    logic [31:0] a_awaddr, a_araddr;
    logic        a_awvalid, a_awready, a_arvalid, a_arready;
    logic [7:0]  a_awlen, a_arlen;
    logic [2:0]  a_awsize, a_arsize;
    logic [1:0]  a_awburst, a_arburst;
    logic        a_wvalid, a_wready, a_wlast;
    logic [63:0] a_wdata;
    logic [7:0]  a_wstrb;
    logic        a_bvalid, a_bready;
    logic [1:0]  a_bresp;
    logic        a_rvalid, a_rready, a_rlast;
    logic [63:0] a_rdata;
    logic [1:0]  a_rresp;

    axi_burst_master #(.ADDR_W(32), .DATA_W(64)) dut (
        .a_clk(a_clk), .a_rst_n(a_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .busy(busy), .done(done), .err(err),
        .a_awaddr(a_awaddr), .a_awvalid(a_awvalid), .a_awready(a_awready),
        .a_awlen(a_awlen), .a_awsize(a_awsize), .a_awburst(a_awburst),
        .a_wvalid(a_wvalid), .a_wready(a_wready), .a_wlast(a_wlast),
        .a_wdata(a_wdata), .a_wstrb(a_wstrb),
        .a_bvalid(a_bvalid), .a_bready(a_bready), .a_bresp(a_bresp),
        .a_arvalid(a_arvalid), .a_arready(a_arready), .a_araddr(a_araddr),
        .a_arsize(a_arsize), .a_arburst(a_arburst), .a_arlen(a_arlen),
        .a_rvalid(a_rvalid), .a_rready(a_rready), .a_rlast(a_rlast),
        .a_rdata(a_rdata), .a_rresp(a_rresp)
    );

    always #5 a_clk = ~a_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: state after the next rising edge.
    bit          m_active, m_done, m_wr, m_addr_ok, m_err;
    int          m_len, m_beats;
    logic [31:0] m_addr;
    logic [63:0] mem [0:511];

    // Per-command observations for the directed checks.
    int rec_aw_cycles, rec_ar_cycles, rec_awlen, rec_wlast_cnt, rec_wlast_beat;
    int rec_rlast_beat, rec_rx, rec_done_cnt;

    // Slave / stream knobs.
    int          rdy_pct   = 100;
    int          rd_mode   = 2;     // 0 random, 1 toggle, 2 always ready
    bit          bresp_err = 1'b0;
    int          rerr_beat = -1;
    int          rlast_at  = -1;
    logic [63:0] wbase     = '0;

    function automatic bit rnd(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Slave and stream driver: new inputs just after each rising edge.
    int drv_idx;
    initial begin
        a_awready = 0; a_arready = 0; a_wready = 0; wr_valid = 0; wr_data = '0;
        rd_ready = 0; a_bvalid = 0; a_bresp = 0; a_rvalid = 0; a_rdata = '0;
        a_rresp = 0; a_rlast = 0;
        forever begin
            @(posedge a_clk); #1;
            a_awready = rnd(rdy_pct);
            a_arready = rnd(rdy_pct);
            a_wready  = rnd(rdy_pct);
            wr_valid  = rnd(rdy_pct);
            a_bvalid  = rnd(rdy_pct);
            case (rd_mode)
                0:       rd_ready = rnd(rdy_pct);
                1:       rd_ready = ~rd_ready;
                default: rd_ready = 1'b1;
            endcase
            wr_data = (m_active && m_wr) ? wbase + 64'(m_beats) : {$urandom, $urandom};
            if (m_active && m_wr && m_beats == m_len + 1)
                a_bresp = bresp_err ? 2'b10 : 2'b00;
            else
                a_bresp = 2'($urandom_range(0, 3));
            if (m_active && !m_wr && m_addr_ok) begin
                drv_idx  = (int'(m_addr[11:3]) + m_beats) & 511;
                a_rvalid = rnd(rdy_pct);
                a_rdata  = mem[drv_idx];
                a_rresp  = (m_beats == rerr_beat) ? 2'b11 : 2'b00;
                a_rlast  = (m_beats == ((rlast_at >= 0) ? rlast_at : m_len));
            end else begin
                a_rvalid = 1'($urandom_range(0, 1));
                a_rdata  = {$urandom, $urandom};
                a_rresp  = 2'($urandom_range(0, 3));
                a_rlast  = 1'($urandom_range(0, 1));
            end
        end
    end

    // Compare process: check every output at the falling edge, then advance
    // the model by the handshakes that the coming rising edge will complete.
    bit exp_busy, aw_exp, ar_exp, w_phase, b_phase, r_phase;
    int cmp_idx;
    initial begin
        forever begin
            @(negedge a_clk);
            if (!a_rst_n) begin
                m_active = 0; m_done = 0; m_addr_ok = 0; m_beats = 0; m_err = 0;
            end else begin
                exp_busy = m_active || m_done;
                aw_exp   = m_active && m_wr && !m_addr_ok;
                ar_exp   = m_active && !m_wr && !m_addr_ok;
                w_phase  = m_active && m_wr && m_addr_ok && (m_beats <= m_len);
                b_phase  = m_active && m_wr && (m_beats == m_len + 1);
                r_phase  = m_active && !m_wr && m_addr_ok;

                chk("busy", busy, exp_busy);
                chk("cmd_ready", cmd_ready, !exp_busy);
                chk("done", done, m_done);
                if (m_done) chk("err", err, m_err);
                chk("awvalid", a_awvalid, aw_exp);
                chk("arvalid", a_arvalid, ar_exp);
                if (aw_exp) begin
                    chk("awaddr", a_awaddr, m_addr);
                    chk("awlen", a_awlen, 64'(m_len));
                    chk("awsize", a_awsize, 3);
                    chk("awburst", a_awburst, 1);
                end
                if (ar_exp) begin
                    chk("araddr", a_araddr, m_addr);
                    chk("arlen", a_arlen, 64'(m_len));
                    chk("arsize", a_arsize, 3);
                    chk("arburst", a_arburst, 1);
                end
                chk("wvalid", a_wvalid, w_phase ? wr_valid : 1'b0);
                chk("wr_ready", wr_ready, w_phase ? a_wready : 1'b0);
                if (w_phase) begin
                    chk("wlast", a_wlast, m_beats == m_len);
                    chk("wdata", a_wdata, wr_data);
                    chk("wstrb", a_wstrb, 8'hFF);
                end
                chk("bready", a_bready, b_phase);
                chk("rready", a_rready, r_phase ? rd_ready : 1'b0);
                chk("rd_valid", rd_valid, r_phase ? a_rvalid : 1'b0);
                if (r_phase) begin
                    chk("rd_data", rd_data, a_rdata);
                    chk("rd_last", rd_last, a_rlast);
                end

                if (a_awvalid) begin rec_aw_cycles++; rec_awlen = int'(a_awlen); end
                if (a_arvalid) rec_ar_cycles++;
                if (done) rec_done_cnt++;

                if (m_done) m_done = 0;
                if (!exp_busy && cmd_valid) begin
                    m_wr = cmd_write; m_addr = cmd_addr; m_len = int'(cmd_len);
                    m_beats = 0; m_addr_ok = 0;
                    rec_aw_cycles = 0; rec_ar_cycles = 0; rec_awlen = -1;
                    rec_wlast_cnt = 0; rec_wlast_beat = -1; rec_rlast_beat = -1;
                    rec_rx = 0; rec_done_cnt = 0;
                    if ((cmd_addr % 8 != 0) ||
                        (int'(cmd_addr[11:0]) + (int'(cmd_len) + 1) * 8 > 4096)) begin
                        m_active = 0; m_done = 1; m_err = 1;
                    end else begin
                        m_active = 1; m_err = 0;
                    end
                end else if (aw_exp && a_awready) begin
                    m_addr_ok = 1;
                end else if (ar_exp && a_arready) begin
                    m_addr_ok = 1;
                end else if (w_phase && wr_valid && a_wready) begin
                    cmp_idx = (int'(m_addr[11:3]) + m_beats) & 511;
                    mem[cmp_idx] = wr_data;
                    if (a_wlast) begin rec_wlast_cnt++; rec_wlast_beat = m_beats; end
                    m_beats++;
                end else if (b_phase && a_bvalid) begin
                    if (a_bresp != 2'b00) m_err = 1;
                    m_active = 0; m_done = 1;
                end else if (r_phase && a_rvalid && rd_ready) begin
                    cmp_idx = (int'(m_addr[11:3]) + m_beats) & 511;
                    chk("rd_beat_data", rd_data, mem[cmp_idx]);
                    rec_rx++;
                    if (rd_last) rec_rlast_beat = m_beats;
                    if (a_rresp != 2'b00) m_err = 1;
                    if (a_rlast) begin
                        if (m_beats != m_len) m_err = 1;
                        m_active = 0; m_done = 1;
                    end
                    m_beats++;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_awvalid"}, a_awvalid, 0);
        chk({tag, "_wvalid"}, a_wvalid, 0);
        chk({tag, "_bready"}, a_bready, 0);
        chk({tag, "_arvalid"}, a_arvalid, 0);
        chk({tag, "_rready"}, a_rready, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_last"}, rd_last, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_awaddr"}, a_awaddr, 0);
        chk({tag, "_awlen"}, a_awlen, 0);
        chk({tag, "_araddr"}, a_araddr, 0);
        chk({tag, "_arlen"}, a_arlen, 0);
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input int len);
        bit got;
        got = 0;
        @(posedge a_clk); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
        for (int i = 0; i < 500; i++) begin
            @(negedge a_clk);
            if (cmd_ready) begin got = 1; break; end
        end
        chk("cmd_accept_timeout", got, 1);
        @(posedge a_clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done(output int lat, output bit derr);
        bit got;
        got = 0; lat = -1; derr = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge a_clk);
            if (done) begin got = 1; lat = i + 1; derr = err; break; end
        end
        chk("done_timeout", got, 1);
        @(negedge a_clk);
    endtask

    task automatic run(input bit wr, input logic [31:0] addr, input int len,
                       output int lat, output bit derr);
        issue(wr, addr, len);
        wait_done(lat, derr);
    endtask

    int lat;
    bit derr;
    bit got5;
    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        a_rst_n = 0;
        for (int k = 0; k < 512; k++) mem[k] = {$urandom, $urandom};
        repeat (3) @(posedge a_clk);
        #1 chk_reset_vals("rst");
        @(negedge a_clk); #2 a_rst_n = 1;

        // 16-beat write, everything ready
        rdy_pct = 100; rd_mode = 2; wbase = '0;
        run(1, 32'h0000_0100, 15, lat, derr);
        chk("w16_awlen", rec_awlen, 15);
        chk("w16_wlast_cnt", rec_wlast_cnt, 1);
        chk("w16_wlast_beat", rec_wlast_beat, 15);
        chk("w16_done_cnt", rec_done_cnt, 1);
        chk("w16_err", derr, 0);
        chk("w16_latency", lat, 19);
        for (int k = 0; k < 16; k++) chk("w16_mem", mem[32 + k], 64'(k));

        // 4-beat read with rd_ready toggling
        rd_mode = 1;
        run(0, 32'h0000_0200, 3, lat, derr);
        chk("r4_beats", rec_rx, 4);
        chk("r4_rlast_beat", rec_rlast_beat, 3);
        chk("r4_err", derr, 0);

        // rejected commands and the exact-fit boundary
        rd_mode = 0; rdy_pct = 60;
        run(1, 32'h0000_0104, 0, lat, derr);
        chk("misalign_lat", lat, 1);
        chk("misalign_err", derr, 1);
        chk("misalign_aw", rec_aw_cycles, 0);
        run(0, 32'h0000_0FF8, 1, lat, derr);
        chk("cross_lat", lat, 1);
        chk("cross_err", derr, 1);
        chk("cross_ar", rec_ar_cycles, 0);
        run(1, 32'h0000_0FF0, 1, lat, derr);
        chk("fit_err", derr, 0);
        chk("fit_aw_seen", rec_aw_cycles > 0, 1);

        // slave error responses
        bresp_err = 1;
        run(1, 32'h0000_0300, 3, lat, derr);
        chk("slverr_err", derr, 1);
        bresp_err = 0; rerr_beat = 2;
        run(0, 32'h0000_0400, 7, lat, derr);
        chk("decerr_err", derr, 1);
        chk("decerr_beats", rec_rx, 8);
        rerr_beat = -1; rlast_at = 4;
        run(0, 32'h0000_0500, 7, lat, derr);
        chk("early_rlast_err", derr, 1);
        chk("early_rlast_beats", rec_rx, 5);
        rlast_at = -1;

        // randomised commands
        for (int n = 0; n < 24; n++) begin
            rdy_pct = $urandom_range(40, 100);
            rd_mode = $urandom_range(0, 2);
            wbase   = {$urandom, $urandom};
            run(1'($urandom_range(0, 1)),
                {20'h0, 9'($urandom_range(0, 511)), 3'b000} + (($urandom_range(0, 7) == 0) ? 32'd4 : 32'd0),
                $urandom_range(0, 31), lat, derr);
            chk("rand_done_cnt", rec_done_cnt, 1);
        end

        // reset during beat 5 of a 32-beat write
        rdy_pct = 100; rd_mode = 2; wbase = 64'h100;
        issue(1, 32'h0000_0000, 31);
        got5 = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_addr_ok && m_beats == 5) begin got5 = 1; break; end
            @(negedge a_clk);
        end
        chk("mid_reset_reach_beat5", got5, 1);
        #2 a_rst_n = 0;
        #1 chk_reset_vals("mid_rst");
        repeat (2) @(negedge a_clk);
        chk("mid_rst_no_done", rec_done_cnt, 0);
        #2 a_rst_n = 1;
        run(1, 32'h0000_0040, 0, lat, derr);
        chk("post_rst_awlen", rec_awlen, 0);
        chk("post_rst_wlast_cnt", rec_wlast_cnt, 1);
        chk("post_rst_wlast_beat", rec_wlast_beat, 0);
        chk("post_rst_err", derr, 0);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_mem", mem[8], 64'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
